// File: rtl/myip_watch_s00_axi.sv
// AXI4-Lite slave exposing four 32-bit watch registers to the watch core.
// Optional `MYIP_WATCH_WR_PULSE_EN adds a per-register write strobe output.
module myip_watch_s00_axi #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
`ifdef MYIP_WATCH_WR_PULSE_EN
  output logic [3:0]                        watch_wr_pulse,
`endif
  output logic [C_S_AXI_DATA_WIDTH-1:0]     watch_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     watch_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     watch_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     watch_reg3
);

  localparam int unsigned STRB_W   = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned NUM_REGS = 4;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
  logic                          bvalid;
  logic                          rvalid;
  logic                          wr_block;
  logic                          rd_block;
  logic                          wr_accept_c;
  logic                          rd_accept_c;
  logic [1:0]                    wr_sel;
  logic [1:0]                    rd_sel;
  logic                          unused_bits;

  assign wr_sel = S_AXI_AWADDR[3:2];
  assign rd_sel = S_AXI_ARADDR[3:2];

  // Block flags come out of reset set, so the first acceptance lands on the
  // second edge after release; afterwards they hold off back-to-back accepts.
  assign wr_accept_c = S_AXI_ARESETN & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid & ~wr_block;
  assign rd_accept_c = S_AXI_ARESETN & S_AXI_ARVALID & ~rvalid & ~rd_block;

  assign S_AXI_AWREADY = wr_accept_c;
  assign S_AXI_WREADY  = wr_accept_c;
  assign S_AXI_ARREADY = rd_accept_c;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = rdata;

  assign watch_reg0 = regs[0];
  assign watch_reg1 = regs[1];
  assign watch_reg2 = regs[2];
  assign watch_reg3 = regs[3];

  // Protection bits and byte offset carry no meaning for word registers.
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write path: byte-lane register update and write response
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wr_block <= 1'b1;
      bvalid   <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      wr_block <= wr_accept_c;
      if (wr_accept_c) begin
        bvalid <= 1'b1;
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (S_AXI_WSTRB[b]) begin
            regs[wr_sel][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
          end
        end
      end else if (S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Read path: data captured at acceptance, held until the R handshake
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rd_block <= 1'b1;
      rvalid   <= 1'b0;
      rdata    <= '0;
    end else begin
      rd_block <= rd_accept_c;
      if (rd_accept_c) begin
        rvalid <= 1'b1;
        rdata  <= regs[rd_sel];
      end else if (S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

`ifdef MYIP_WATCH_WR_PULSE_EN
  // One-hot strobe rising together with the register it names
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      watch_wr_pulse <= 4'b0000;
    end else if (wr_accept_c) begin
      watch_wr_pulse <= 4'(4'b0001 << wr_sel);
    end else begin
      watch_wr_pulse <= 4'b0000;
    end
  end
`endif

endmodule
